cond_flags_unit: RTL and testbench

Condition-evaluation and flag-register stage sitting directly downstream of the ALU. It latches the 4-bit ALU flag vector (N,Z,C,V) into an architectural flag register under per-group write enables. It evaluates the instruction's 4-bit condition field against the currently held flags and gates the instruction's PC-write, register-write and memory-write requests, honouring pipeline stall and flush.

---
 rtl/alu_defs_pkg.sv | 31 +++
 rtl/cond_flags_unit_cond_check.sv | 39 +++
 rtl/cond_flags_unit.sv | 67 ++++++
 tb/tb_cond_flags_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: condition codes, flag bit positions
// and the flag register reset value.
package alu_defs;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] RESET_FLAGS = 4'b0000;

endpackage

// File: rtl/cond_flags_unit_cond_check.sv
// Combinational 16-way condition decode against held flags.
// Encoding 15 behaves as always.
module cond_check
    import alu_defs::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    always_comb begin
        n = flags_i[FLAG_N];
        z = flags_i[FLAG_Z];
        c = flags_i[FLAG_C];
        v = flags_i[FLAG_V];
        cond_ex_o = 1'b1;
        case (cond_e'(cond_i))
            EQ: cond_ex_o = z;
            NE: cond_ex_o = ~z;
            CS: cond_ex_o = c;
            CC: cond_ex_o = ~c;
            MI: cond_ex_o = n;
            PL: cond_ex_o = ~n;
            VS: cond_ex_o = v;
            VC: cond_ex_o = ~v;
            HI: cond_ex_o = c & ~z;
            LS: cond_ex_o = ~c | z;
            GE: cond_ex_o = (n == v);
            LT: cond_ex_o = (n != v);
            GT: cond_ex_o = ~z & (n == v);
            LE: cond_ex_o = z | (n != v);
            AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flags_unit.sv
// Flag register plus condition gating of PC, register and
// memory write requests, honouring stall and flush.
module cond_flags_unit
    import alu_defs::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       valid_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       no_write_i,
    output logic [3:0] flags_o,
    output logic       cond_ex_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic       mem_write_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       commit;

    cond_check u_cond_check (
        .cond_i    (cond_i),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign commit = valid_i & ~stall_i & ~flush_i & cond_ex;

    // Each write-enable group updates its pair of flags independently.
    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (flag_w_i[1]) begin
                flags_d[FLAG_N] = alu_flags_i[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
            end
            if (flag_w_i[0]) begin
                flags_d[FLAG_C] = alu_flags_i[FLAG_C];
                flags_d[FLAG_V] = alu_flags_i[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o     = flags_q;
    assign cond_ex_o   = cond_ex;
    assign pc_src_o    = commit & pcs_i;
    assign mem_write_o = commit & mem_w_i;
    assign reg_write_o = commit & reg_w_i & ~no_write_i;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Vector table, exhaustive condition sweep and reset corner for
// cond_flags_unit, checked through an expected-result queue.
module tb_cond_flags_unit;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       valid_i, stall_i, flush_i;
    logic [3:0] cond_i, alu_flags_i;
    logic [1:0] flag_w_i;
    logic       pcs_i, reg_w_i, mem_w_i, no_write_i;
    logic [3:0] flags_o;
    logic       cond_ex_o, pc_src_o, reg_write_o, mem_write_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic       v, st, fl;
        logic [3:0] c, af;
        logic [1:0] fw;
        logic       p, r, m, nw;
        logic       ex, epc, erg, emm;
        logic [3:0] ef;
    } vec_t;

    typedef struct {
        string      nm;
        logic       ex, epc, erg, emm;
        logic [3:0] ef;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[22];

    cond_flags_unit dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .cond_i      (cond_i),
        .alu_flags_i (alu_flags_i),
        .flag_w_i    (flag_w_i),
        .pcs_i       (pcs_i),
        .reg_w_i     (reg_w_i),
        .mem_w_i     (mem_w_i),
        .no_write_i  (no_write_i),
        .flags_o     (flags_o),
        .cond_ex_o   (cond_ex_o),
        .pc_src_o    (pc_src_o),
        .reg_write_o (reg_write_o),
        .mem_write_o (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(
        string nm, logic v, logic st, logic fl,
        logic [3:0] c, logic [3:0] af, logic [1:0] fw,
        logic p, logic r, logic m, logic nw,
        logic ex, logic epc, logic erg, logic emm,
        logic [3:0] ef);
        vec_t t;
        t.nm = nm; t.v = v; t.st = st; t.fl = fl;
        t.c = c; t.af = af; t.fw = fw;
        t.p = p; t.r = r; t.m = m; t.nw = nw;
        t.ex = ex; t.epc = epc; t.erg = erg; t.emm = emm;
        t.ef = ef;
        return t;
    endfunction

    // Reference condition table, flags given as {N,Z,C,V}.
    function automatic logic ref_cond(int c, logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;
            1: return !z;
            2: return cy;
            3: return !cy;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return cy && !z;
            9: return !cy || z;
            10: return n ~^ v;
            11: return n ^ v;
            12: return !z && (n ~^ v);
            13: return z || (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(string nm, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 want 1");
            return;
        end
        e = sb.pop_front();
        chk({e.nm, ".cond_ex"}, {3'b0, cond_ex_o}, {3'b0, e.ex});
        chk({e.nm, ".pc_src"}, {3'b0, pc_src_o}, {3'b0, e.epc});
        chk({e.nm, ".reg_write"}, {3'b0, reg_write_o}, {3'b0, e.erg});
        chk({e.nm, ".mem_write"}, {3'b0, mem_write_o}, {3'b0, e.emm});
        chk({e.nm, ".flags"}, flags_o, e.ef);
    endtask

    task automatic run(input vec_t t);
        exp_t e;
        valid_i = t.v; stall_i = t.st; flush_i = t.fl;
        cond_i = t.c; alu_flags_i = t.af; flag_w_i = t.fw;
        pcs_i = t.p; reg_w_i = t.r; mem_w_i = t.m;
        no_write_i = t.nw;
        e.nm = t.nm; e.ex = t.ex; e.epc = t.epc;
        e.erg = t.erg; e.emm = t.emm; e.ef = t.ef;
        sb.push_back(e);
        @(negedge clk_i);
        compare_head();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i = 0; stall_i = 0; flush_i = 0;
        cond_i = 4'd14; alu_flags_i = 0; flag_w_i = 0;
        pcs_i = 0; reg_w_i = 0; mem_w_i = 0; no_write_i = 0;
    endtask

    initial begin
        logic [3:0] cur;
        tbl[0]  = mk("al_reg",  1,0,0, 14,4'h0,2'b00, 0,1,0,0, 1,0,1,0, 4'b0000);
        tbl[1]  = mk("grp_nz",  1,0,0, 14,4'hF,2'b10, 0,0,0,0, 1,0,0,0, 4'b0000);
        tbl[2]  = mk("grp_cv0", 1,0,0, 14,4'h0,2'b01, 0,0,0,0, 1,0,0,0, 4'b1100);
        tbl[3]  = mk("grp_cv1", 1,0,0, 14,4'h3,2'b01, 0,0,0,0, 1,0,0,0, 4'b1100);
        tbl[4]  = mk("grp_all", 0,0,0, 14,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'b1111);
        tbl[5]  = mk("clr",     1,0,0, 14,4'h0,2'b11, 0,0,0,0, 1,0,0,0, 4'b1111);
        tbl[6]  = mk("eq_fail", 1,0,0, 0, 4'hF,2'b11, 1,0,1,0, 0,0,0,0, 4'b0000);
        tbl[7]  = mk("eq_hold", 0,0,0, 0, 4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'b0000);
        tbl[8]  = mk("stall",   1,1,0, 14,4'hA,2'b11, 1,1,1,0, 1,0,0,0, 4'b0000);
        tbl[9]  = mk("st_fl",   1,1,1, 14,4'hA,2'b11, 1,1,1,0, 1,0,0,0, 4'b0000);
        tbl[10] = mk("flush",   1,0,1, 14,4'hA,2'b11, 1,1,1,0, 1,0,0,0, 4'b0000);
        tbl[11] = mk("release", 1,0,0, 14,4'hA,2'b11, 1,1,1,0, 1,1,1,1, 4'b0000);
        tbl[12] = mk("rel_fl",  0,0,0, 14,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'b1010);
        tbl[13] = mk("ge_no",   0,0,0, 10,4'h0,2'b00, 0,0,0,0, 0,0,0,0, 4'b1010);
        tbl[14] = mk("lt_yes",  0,0,0, 11,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'b1010);
        tbl[15] = mk("hi_yes",  0,0,0, 8, 4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'b1010);
        tbl[16] = mk("cmp",     1,0,0, 14,4'h5,2'b11, 0,1,0,1, 1,0,0,0, 4'b1010);
        tbl[17] = mk("cmp_fl",  0,0,0, 14,4'h0,2'b00, 0,0,0,0, 1,0,0,0, 4'b0101);
        tbl[18] = mk("b2b_clr", 1,0,0, 14,4'h0,2'b11, 0,0,0,0, 1,0,0,0, 4'b0101);
        tbl[19] = mk("b2b_eq",  1,0,0, 0, 4'h4,2'b10, 0,1,0,0, 0,0,0,0, 4'b0000);
        tbl[20] = mk("b2b_ne",  1,0,0, 1, 4'h4,2'b10, 0,1,0,0, 1,0,1,0, 4'b0000);
        tbl[21] = mk("b2b_eq2", 1,0,0, 0, 4'h0,2'b00, 0,1,0,0, 1,0,1,0, 4'b0100);

        idle();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_flags", flags_o, 4'b0000);
        chk("rst_writes", {1'b0, pc_src_o, reg_write_o, mem_write_o}, 4'b0000);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        for (int i = 0; i < 22; i++) run(tbl[i]);

        // Mid-operation reset with a committing write pending.
        valid_i = 1; cond_i = 4'd14; alu_flags_i = 4'hF; flag_w_i = 2'b11;
        @(negedge clk_i);
        chk("pre_rst_flags", flags_o, 4'b0100);
        rst_n_i = 1'b0;
        #1;
        chk("rst_async", flags_o, 4'b0000);
        @(posedge clk_i);
        #1;
        chk("rst_hold", flags_o, 4'b0000);
        idle();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        run(mk("post_rst", 1,0,0, 14,4'h0,2'b00, 0,1,0,0, 1,0,1,0, 4'b0000));

        cur = 4'b0000;
        for (int f = 0; f < 16; f++) begin
            run(mk("sweep_set", 1,0,0, 14,4'(f),2'b11, 0,0,0,0,
                   1,0,0,0, cur));
            cur = 4'(f);
            for (int c = 0; c < 16; c++) begin
                run(mk($sformatf("sweep_f%0d_c%0d", f, c),
                       0,0,0, 4'(c),4'h0,2'b00, 0,0,0,0,
                       ref_cond(c, cur),0,0,0, cur));
            end
        end

        chk("sb_drained", 4'(sb.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
